// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, datapath
// select codes and trap causes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRd    = 4'd3,
      StMemWb    = 4'd4,
      StMemWr    = 4'd5,
      StRtExec   = 4'd6,
      StAluWb    = 4'd7,
      StBranch   = 4'd8,
      StAddiExec = 4'd9,
      StAddiWb   = 4'd10,
      StJump     = 4'd11,
      StTrap     = 4'd12
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [1:0] AluAdd   = 2'b00;
   localparam logic [1:0] AluSub   = 2'b01;
   localparam logic [1:0] AluFunct = 2'b10;

   localparam logic [1:0] PcAlu    = 2'b00;
   localparam logic [1:0] PcAluOut = 2'b01;
   localparam logic [1:0] PcJump   = 2'b10;
   localparam logic [1:0] PcTrap   = 2'b11;

   localparam logic [1:0] SrcBReg   = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] SrcBImmSh = 2'b11;

   localparam logic [1:0] CauseNone    = 2'b00;
   localparam logic [1:0] CauseIllegal = 2'b01;
   localparam logic [1:0] CauseTimeout = 2'b10;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from controller state to datapath strobes and selects.
module ctrl_output_decode
   import ctrl_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic       mem_ready_i,
   input  logic       trap_ack_i,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic       ior_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic       reg_write_o,
   output logic       reg_dst_o,
   output logic [1:0] pc_source_o,
   output logic [1:0] alu_op_o,
   output logic [1:0] alu_src_b_o,
   output logic       trap_o
);

   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      ior_d_o         = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      mem_to_reg_o    = 1'b0;
      alu_src_a_o     = 1'b0;
      reg_write_o     = 1'b0;
      reg_dst_o       = 1'b0;
      pc_source_o     = PcAlu;
      alu_op_o        = AluAdd;
      alu_src_b_o     = SrcBReg;
      trap_o          = 1'b0;
      case (state_i)
         StFetch: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SrcBFour;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         StDecode: alu_src_b_o = SrcBImmSh;
         StMemAdr: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SrcBImm;
         end
         StMemRd: begin
            ior_d_o    = 1'b1;
            mem_read_o = 1'b1;
         end
         StMemWb: begin
            mem_to_reg_o = 1'b1;
            reg_write_o  = 1'b1;
         end
         StMemWr: begin
            ior_d_o     = 1'b1;
            mem_write_o = 1'b1;
         end
         StRtExec: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = AluFunct;
         end
         StAluWb: begin
            reg_dst_o   = 1'b1;
            reg_write_o = 1'b1;
         end
         StBranch: begin
            alu_src_a_o     = 1'b1;
            alu_op_o        = AluSub;
            pc_write_cond_o = 1'b1;
            pc_source_o     = PcAluOut;
         end
         StAddiExec: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SrcBImm;
         end
         StAddiWb: reg_write_o = 1'b1;
         StJump: begin
            pc_write_o  = 1'b1;
            pc_source_o = PcJump;
         end
         StTrap: begin
            trap_o = 1'b1;
            // Redirect to the trap vector only in the acknowledge cycle
            if (trap_ack_i) begin
               pc_write_o  = 1'b1;
               pc_source_o = PcTrap;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: next-state sequencing, memory wait counter with
// timeout trap, and reset gating of the write/read strobes.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter bit          TRAP_ENABLE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        mem_ready,
   input  logic        trap_ack,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        MemtoReg,
   output logic        ALUSrcA,
   output logic        RegWrite,
   output logic        RegDst,
   output logic [1:0]  PCSource,
   output logic [1:0]  ALUOp,
   output logic [1:0]  ALUSrcB,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [3:0]  state
);

   localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] cause_q, cause_d;
   logic [5:0] opcode;
   logic       waiting;
   logic       timeout;
   logic       unused_instr;

   assign opcode       = instruction[31:26];
   assign unused_instr = ^instruction[25:0];
   assign waiting      = state_q inside {StFetch, StMemRd, StMemWr};
   // The wait that would bring the counter to MEM_TIMEOUT traps instead
   assign timeout      = TRAP_ENABLE && !mem_ready && (cnt_q == TimeoutLast);

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         StFetch, StMemRd, StMemWr: begin
            if (mem_ready) begin
               case (state_q)
                  StFetch: state_d = StDecode;
                  StMemRd: state_d = StMemWb;
                  default: state_d = StFetch;
               endcase
            end else if (timeout) begin
               state_d = StTrap;
               cause_d = CauseTimeout;
            end
         end
         StDecode: begin
            case (opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StRtExec;
               OpBeq:      state_d = StBranch;
               OpAddi:     state_d = StAddiExec;
               OpJ:        state_d = StJump;
               default: begin
                  if (TRAP_ENABLE) begin
                     state_d = StTrap;
                     cause_d = CauseIllegal;
                  end else begin
                     state_d = StFetch;
                  end
               end
            endcase
         end
         StMemAdr: begin
            if (opcode == OpLw) begin
               state_d = StMemRd;
            end else if (opcode == OpSw) begin
               state_d = StMemWr;
            end else begin
               state_d = StFetch;
            end
         end
         StRtExec:   state_d = StAluWb;
         StAddiExec: state_d = StAddiWb;
         StTrap: begin
            if (trap_ack) begin
               state_d = StFetch;
               cause_d = CauseNone;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (waiting && !mem_ready && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         cnt_q   <= '0;
         cause_q <= CauseNone;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   logic dec_pc_write, dec_mem_read, dec_mem_write, dec_ir_write, dec_reg_write;

   ctrl_output_decode u_decode (
      .state_i         (state_q),
      .mem_ready_i     (mem_ready),
      .trap_ack_i      (trap_ack),
      .pc_write_o      (dec_pc_write),
      .pc_write_cond_o (PCWriteCond),
      .ior_d_o         (IorD),
      .mem_read_o      (dec_mem_read),
      .mem_write_o     (dec_mem_write),
      .ir_write_o      (dec_ir_write),
      .mem_to_reg_o    (MemtoReg),
      .alu_src_a_o     (ALUSrcA),
      .reg_write_o     (dec_reg_write),
      .reg_dst_o       (RegDst),
      .pc_source_o     (PCSource),
      .alu_op_o        (ALUOp),
      .alu_src_b_o     (ALUSrcB),
      .trap_o          (trap)
   );

   // Side-effecting strobes are held off while reset is asserted
   assign PCWrite    = dec_pc_write & rst_n;
   assign MemRead    = dec_mem_read & rst_n;
   assign MemWrite   = dec_mem_write & rst_n;
   assign IRWrite    = dec_ir_write & rst_n;
   assign RegWrite   = dec_reg_write & rst_n;
   assign trap_cause = cause_q;
   assign state      = state_q;

endmodule
